// File: rtl/life_seed_loader_if.sv
// -----------------------------------------------------------------------------
// life_seed_loader_if
// Groups the load-request and row-write signals of the Game-of-Life seed
// loader. The controller side drives start/mode/seed and watches the row-write
// port plus busy/done. The loader side receives the request and drives the
// row-write port.
//
// Signals:
//   start    single-cycle load request
//   mode     pattern select (0 clear, 1 glider, 2 blinker, 3 random)
//   seed     LFSR seed for the random pattern
//   wr_en    row write strobe
//   wr_row   row index being written (ROW_AW bits)
//   wr_data  row contents, bit c = column c, 1 = live (GRID_W bits)
//   busy     high while rows are being written
//   done     one-cycle completion pulse
//
// Modports:
//   master  controller / grid side
//   slave   the loader itself
// -----------------------------------------------------------------------------
interface life_seed_loader_if #(
    parameter int GRID_W = 8,
    parameter int ROW_AW = 3
);
    logic              start;
    logic [1:0]        mode;
    logic [15:0]       seed;
    logic              wr_en;
    logic [ROW_AW-1:0] wr_row;
    logic [GRID_W-1:0] wr_data;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, seed,
        input  wr_en, wr_row, wr_data, busy, done
    );

    modport slave (
        input  start, mode, seed,
        output wr_en, wr_row, wr_data, busy, done
    );
endinterface

// File: rtl/life_seed_loader.sv
// -----------------------------------------------------------------------------
// life_seed_loader
// Fills the Game-of-Life grid with a selectable seed pattern, one full row per
// clock, through a row-write port. The generation engine must not step while
// busy is high.
//
// Ports:
//   c1   input   system clock, all logic on the rising edge
//   rst  input   synchronous active-high reset (aborts any load in progress)
//   bus  slave   life_seed_loader_if: start/mode/seed in,
//                wr_en/wr_row/wr_data/busy/done out
//
// Timing: start sampled at edge N -> row 0 write visible after edge N+1,
// row GRID_H-1 after edge N+GRID_H, done high after edge N+GRID_H+1.
// -----------------------------------------------------------------------------
module life_seed_loader #(
    parameter int          GRID_W   = 8,
    parameter int          GRID_H   = 8,
    parameter int          ROW_AW   = 3,
    parameter logic [15:0] LFSR_DEF = 16'hACE1
) (
    input  logic                c1,
    input  logic                rst,
    life_seed_loader_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] MODE_CLEAR   = 2'd0;
    localparam logic [1:0] MODE_GLIDER  = 2'd1;
    localparam logic [1:0] MODE_BLINKER = 2'd2;
    localparam logic [1:0] MODE_RANDOM  = 2'd3;

    localparam int MC = GRID_W / 2;
    localparam int MR = GRID_H / 2;

    localparam logic [ROW_AW-1:0] ROW_0    = '0;
    localparam logic [ROW_AW-1:0] ROW_1    = ROW_AW'(1);
    localparam logic [ROW_AW-1:0] ROW_2    = ROW_AW'(2);
    localparam logic [ROW_AW-1:0] ROW_MID  = ROW_AW'(MR);
    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(GRID_H - 1);

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [1:0]        state_reg;
    logic [1:0]        mode_reg;
    logic [15:0]       lfsr_reg;
    logic [ROW_AW-1:0] row_reg;
    logic              wr_en_reg;
    logic [ROW_AW-1:0] wr_row_reg;
    logic [GRID_W-1:0] wr_data_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [15:0]       lfsr_next;
    logic [GRID_W-1:0] rnd_row;
    logic [GRID_W-1:0] fixed_row;
    logic [GRID_W-1:0] row_data;

    // Random row: the Galois LFSR is stepped GRID_W times in one cycle; the
    // output bit of step c+1 becomes column c, and the final state is kept
    // for the next row.
    always_comb begin
        logic [15:0] st;
        st      = lfsr_reg;
        rnd_row = '0;
        for (int c = 0; c < GRID_W; c++) begin
            rnd_row[c] = st[0];
            st = (st >> 1) ^ (st[0] ? LFSR_MASK : 16'h0000);
        end
        lfsr_next = st;
    end

    // Fixed patterns, evaluated per column. Each column knows at elaboration
    // time whether it belongs to the glider or blinker shapes, so the
    // run-time logic only compares the row counter and mode.
    genvar gi;
    generate
        for (gi = 0; gi < GRID_W; gi++) begin : g_col
            localparam bit IN_G_ROW0 = (gi == 1);
            localparam bit IN_G_ROW1 = (gi == 2);
            localparam bit IN_G_ROW2 = (gi <= 2);
            localparam bit IN_BLINK  = (gi >= MC - 1) && (gi <= MC + 1);

            logic glider_bit;
            logic blinker_bit;

            assign glider_bit  = ((row_reg == ROW_0) && IN_G_ROW0) ||
                                 ((row_reg == ROW_1) && IN_G_ROW1) ||
                                 ((row_reg == ROW_2) && IN_G_ROW2);
            assign blinker_bit = (row_reg == ROW_MID) && IN_BLINK;

            assign fixed_row[gi] = ((mode_reg == MODE_GLIDER)  && glider_bit) ||
                                   ((mode_reg == MODE_BLINKER) && blinker_bit);
        end
    endgenerate

    always_comb begin
        row_data = '0;
        case (mode_reg)
            MODE_CLEAR:  row_data = '0;
            MODE_RANDOM: row_data = rnd_row;
            default:     row_data = fixed_row;
        endcase
    end

    always_ff @(posedge c1) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            mode_reg    <= MODE_CLEAR;
            lfsr_reg    <= LFSR_DEF;
            row_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_row_reg  <= '0;
            wr_data_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        mode_reg  <= bus.mode;
                        // A zero state would lock the LFSR, so substitute.
                        lfsr_reg  <= (bus.seed == 16'h0000) ? LFSR_DEF : bus.seed;
                        row_reg   <= '0;
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wr_en_reg   <= 1'b1;
                    busy_reg    <= 1'b1;
                    wr_row_reg  <= row_reg;
                    wr_data_reg <= row_data;
                    if (mode_reg == MODE_RANDOM) begin
                        lfsr_reg <= lfsr_next;
                    end
                    // Terminal compare against GRID_H-1 so a non-power-of-two
                    // height never wraps the counter.
                    if (row_reg == ROW_LAST) begin
                        state_reg <= S_DONE;
                    end else begin
                        row_reg <= row_reg + ROW_AW'(1);
                    end
                end
                S_DONE: begin
                    // wr_row/wr_data keep their last values; consumers
                    // qualify them with wr_en.
                    wr_en_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_row  = wr_row_reg;
    assign bus.wr_data = wr_data_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;

endmodule

// File: tb/tb_life_seed_loader.sv
// -----------------------------------------------------------------------------
// tb_life_seed_loader
// Directed bench for life_seed_loader on an 8x8 grid. A negedge monitor
// records every row write, done pulse and busy cycle; a single linear
// initial block drives the steps and checks the recordings.
// -----------------------------------------------------------------------------
module tb_life_seed_loader;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 3;

    logic c1  = 1'b0;
    logic rst = 1'b1;

    life_seed_loader_if #(.GRID_W(W), .ROW_AW(AW)) bus ();

    life_seed_loader #(
        .GRID_W   (W),
        .GRID_H   (H),
        .ROW_AW   (AW),
        .LFSR_DEF (16'hACE1)
    ) dut (
        .c1  (c1),
        .rst (rst),
        .bus (bus)
    );

    always #5 c1 = ~c1;

    int tests = 0;
    int fails = 0;

    int ncyc        = 0;
    int st_cyc      = 0;
    int wr_cnt      = 0;
    int done_cnt    = 0;
    int busy_cnt    = 0;
    int nz_cnt      = 0;
    int done_at     = -1;
    int first_wr_at = -1;

    logic [AW-1:0] row_seen  [16];
    logic [W-1:0]  data_seen [16];
    logic [W-1:0]  exp_rows  [H];
    logic [W-1:0]  saved     [H];

    always @(negedge c1) begin
        ncyc++;
        if (bus.wr_en) begin
            if (wr_cnt < 16) begin
                row_seen[wr_cnt]  = bus.wr_row;
                data_seen[wr_cnt] = bus.wr_data;
            end
            if (first_wr_at < 0) first_wr_at = ncyc;
            wr_cnt++;
        end
        if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = ncyc;
        end
        if (bus.busy) busy_cnt++;
        if (bus.wr_data != '0) nz_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        wr_cnt      = 0;
        done_cnt    = 0;
        busy_cnt    = 0;
        nz_cnt      = 0;
        done_at     = -1;
        first_wr_at = -1;
    endtask

    // Drive start for one cycle; edge N samples it, st_cyc marks that edge.
    task automatic pulse_start(input logic [1:0] m, input logic [15:0] s);
        @(posedge c1);
        #1;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.seed  = s;
        @(posedge c1);
        #1;
        bus.start = 1'b0;
        st_cyc    = ncyc;
    endtask

    // Bounded wait, then check the whole recorded load against exp_rows.
    task automatic check_load(input string tag);
        repeat (14) @(posedge c1);
        #1;
        chk($sformatf("%s writes", tag), 32'(wr_cnt), 32'(H));
        chk($sformatf("%s done_pulses", tag), 32'(done_cnt), 32'd1);
        chk($sformatf("%s busy_cycles", tag), 32'(busy_cnt), 32'(H));
        chk($sformatf("%s done_latency", tag), 32'(done_at - st_cyc), 32'd10);
        chk($sformatf("%s first_write_latency", tag), 32'(first_wr_at - st_cyc), 32'd2);
        for (int r = 0; r < H; r++) begin
            chk($sformatf("%s row_order[%0d]", tag, r), 32'(row_seen[r]), 32'(r));
            chk($sformatf("%s row_data[%0d]", tag, r), 32'(data_seen[r]), 32'(exp_rows[r]));
        end
    endtask

    // Reference LFSR: 16-bit right-shifting Galois, mask B400, GRID_W steps per row.
    function automatic logic [W-1:0] model_row(input logic [15:0] st_in, output logic [15:0] st_out);
        logic [15:0] s;
        logic [W-1:0] r;
        s = st_in;
        r = '0;
        for (int c = 0; c < W; c++) begin
            r[c] = s[0];
            if (s[0]) s = (s >> 1) ^ 16'hB400;
            else      s = s >> 1;
        end
        st_out = s;
        return r;
    endfunction

    task automatic model_load(input logic [15:0] seed_v);
        logic [15:0] s;
        logic [15:0] nx;
        s = seed_v;
        for (int r = 0; r < H; r++) begin
            exp_rows[r] = model_row(s, nx);
            s = nx;
        end
    endtask

    task automatic set_zero_rows();
        for (int r = 0; r < H; r++) exp_rows[r] = '0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        bus.seed  = 16'h0000;
        rst       = 1'b1;

        // Reset state
        repeat (3) @(posedge c1);
        #1;
        chk("reset wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset wr_data", 32'(bus.wr_data), 32'd0);
        chk("reset wr_row", 32'(bus.wr_row), 32'd0);

        // Idle with start low
        rst = 1'b0;
        clr_mon();
        repeat (20) @(posedge c1);
        #1;
        chk("idle writes", 32'(wr_cnt), 32'd0);
        chk("idle busy_cycles", 32'(busy_cnt), 32'd0);
        chk("idle done_pulses", 32'(done_cnt), 32'd0);
        chk("idle nonzero_data", 32'(nz_cnt), 32'd0);

        // Clear
        set_zero_rows();
        clr_mon();
        pulse_start(2'd0, 16'h0000);
        check_load("clear");

        // Glider
        set_zero_rows();
        exp_rows[0] = 8'h02;
        exp_rows[1] = 8'h04;
        exp_rows[2] = 8'h07;
        clr_mon();
        pulse_start(2'd1, 16'h0000);
        check_load("glider");

        // Blinker
        set_zero_rows();
        exp_rows[4] = 8'h38;
        clr_mon();
        pulse_start(2'd2, 16'h0000);
        check_load("blinker");

        // Random, seed 1 (first two rows also worked by hand: 01, 68)
        model_load(16'h0001);
        clr_mon();
        pulse_start(2'd3, 16'h0001);
        check_load("rand_seed1");
        chk("rand_seed1 hand_row0", 32'(data_seen[0]), 32'h01);
        chk("rand_seed1 hand_row1", 32'(data_seen[1]), 32'h68);

        // Random, seed ACE1 then seed 0 (substituted by ACE1)
        model_load(16'hACE1);
        clr_mon();
        pulse_start(2'd3, 16'hACE1);
        check_load("rand_ace1");
        for (int r = 0; r < H; r++) saved[r] = data_seen[r];

        clr_mon();
        pulse_start(2'd3, 16'h0000);
        check_load("rand_seed0");
        for (int r = 0; r < H; r++) begin
            chk($sformatf("seed0_vs_ace1 row[%0d]", r), 32'(data_seen[r]), 32'(saved[r]));
        end

        // Busy protection: second start with a different mode during LOAD
        set_zero_rows();
        exp_rows[0] = 8'h02;
        exp_rows[1] = 8'h04;
        exp_rows[2] = 8'h07;
        clr_mon();
        pulse_start(2'd1, 16'h0000);
        @(posedge c1);
        #1;
        bus.start = 1'b1;
        bus.mode  = 2'd2;
        @(posedge c1);
        #1;
        bus.start = 1'b0;
        check_load("busy_protect");

        // Reset during the row 4 write
        clr_mon();
        pulse_start(2'd2, 16'h0000);
        repeat (5) @(posedge c1);
        #1;
        rst = 1'b1;
        @(posedge c1);
        #1;
        chk("midrst wr_en", 32'(bus.wr_en), 32'd0);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        repeat (12) @(posedge c1);
        #1;
        chk("midrst done_pulses", 32'(done_cnt), 32'd0);
        chk("midrst writes", 32'(wr_cnt), 32'd5);

        // Full normal load after the aborted one
        set_zero_rows();
        exp_rows[0] = 8'h02;
        exp_rows[1] = 8'h04;
        exp_rows[2] = 8'h07;
        clr_mon();
        pulse_start(2'd1, 16'h0000);
        check_load("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/life_seed_loader.md
Name: life_seed_loader

Overview:
- Parametrised successor to the constant-zero initial-state driver.
- Fills the Game-of-Life cell grid with a selectable seed pattern, one full row per clock, through a row-write port into the grid storage.
- Sits between the top-level control (start/mode from buttons or switches) and the generation engine.
- The engine must not step while `busy` is high.

Parameters:
- GRID_W, 8, cells per row (bits of `wr_data`); legal range ≥4.
- GRID_H, 8, number of rows; legal range ≥4.
- ROW_AW, 3, width of the row address; must satisfy 2^ROW_AW ≥ GRID_H.
- LFSR_DEF, 16'hACE1, substitute seed used when the supplied seed is zero.

Ports:
- c1  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle load request.
- mode  input  2  pattern select: 0 clear, 1 glider, 2 blinker, 3 random.
- seed  input  16  LFSR seed for mode 3.
- wr_en  output  1  row write strobe.
- wr_row  output  ROW_AW  row index being written.
- wr_data  output  GRID_W  row contents; bit c = column c, 1 = live.
- busy  output  1  high while loading.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; wr_en=0, wr_row=0, wr_data=0, busy=0, done=0; LFSR=LFSR_DEF. Reset wins over every other event.
- Reset mid-load: the load aborts immediately. No further writes and no done pulse occur. The grid is left partially written; this is acceptable.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - start=1 latches mode and seed.
  - If seed=0, the LFSR is loaded with LFSR_DEF; otherwise it is loaded with seed.
  - Clears the row counter and goes to LOAD. busy=1 from the next cycle.
- LOAD:
  - wr_en=1 every cycle; wr_row = counter; wr_data = pattern(row).
  - The counter increments each cycle.
  - After the write of row GRID_H-1, go to DONE.
- DONE: wr_en=0, busy=0, done=1 for exactly one cycle, then IDLE.
- start is ignored while in LOAD or DONE. It is not queued.
- Latency: start sampled at edge N gives the row 0 write visible after edge N+1. Row GRID_H-1 is visible after edge N+GRID_H. done is high after edge N+GRID_H+1. Total time is GRID_H+2 cycles start-to-IDLE.
- wr_row and wr_data hold their last values when wr_en=0. Consumers qualify them with wr_en.
- Patterns, with mc = GRID_W/2 and mr = GRID_H/2 (integer division):
  - mode 0 (clear): every row = 0. This is the legacy behaviour.
  - mode 1 (glider, top-left):
    - row0 = bit1;
    - row1 = bit2;
    - row2 = bits0,1,2;
    - all other rows 0.
  - mode 2 (blinker): row mr = bits mc-1, mc, mc+1; all other rows 0.
  - mode 3 (random):
    - 16-bit Galois LFSR, right-shifting, feedback mask 16'hB400.
    - One step: out = lfsr[0]; lfsr = (lfsr>>1) ^ (out ? 16'hB400 : 0).
    - Per row, the LFSR is stepped GRID_W times, unrolled combinationally within one cycle.
    - wr_data[c] = out of step c+1.
    - The stepped state is registered for the next row.
- The LFSR is never zero: zero seed is substituted as above, and a Galois step cannot reach zero.
- Widths: the row counter is ROW_AW bits. The terminal compare is against GRID_H-1, so no wrap occurs when GRID_H < 2^ROW_AW.

Test Plan:
- Reset then idle: hold rst 3 cycles, then release with start=0 for 20 cycles -> wr_en, busy and done all 0 throughout; wr_data=0.
- Clear, 8x8: start with mode=0 -> 8 writes, rows 0..7 in order, all 8'h00, on consecutive cycles. done pulses exactly once, 9 cycles after start is sampled; busy is high for exactly 8 cycles.
- Glider/blinker, 8x8:
  - mode=1 -> rows 0..2 = 8'h02, 8'h04, 8'h07; rows 3..7 = 0.
  - mode=2 -> row 4 = 8'h38; all other rows 0.
- Random seeding:
  - mode=3, seed=16'h0001 -> all 8 rows match a bit-exact software model of the LFSR.
  - A repeat with seed=0 produces output identical to a run with seed=16'hACE1.
- Busy protection: pulse start again at the 3rd LOAD cycle with a different mode -> ignored. Exactly 8 writes of the original pattern and one done pulse.
- Reset mid-load: assert rst during the row 4 write -> wr_en=0 and busy=0 the next cycle, with no done pulse. A following start completes a full, normal 8-row load.
